// File: rtl/sdram_pattern_tester.sv
// Self-checking SDRAM traffic generator: writes P(a) = a ^ seed over a range, reads it back and
// compares every word. Sits on the controller's host command port in the m_clock domain.
module sdram_pattern_tester #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] seed,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [TW-1:0]     ONE_T     = TW'(1);
  localparam logic [TW-1:0]     TMO_C     = TW'(TIMEOUT);
  localparam logic [3:0]        MAX_OUT_C = 4'(MAX_OUT);

  // Size cast truncates or zero-extends the address to the data width.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a,
                                            input logic [DATA_W-1:0] s);
    return DATA_W'(a) ^ s;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, len_q, len_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [ADDR_W-1:0] wr_q, wr_d, rd_q, rd_d, chk_q, chk_d;
  logic [3:0]        out_q, out_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              cmd_valid_q, cmd_valid_d, cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic              done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;
  logic              hs, rdv, active;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    seed_d      = seed_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    chk_d       = chk_q;
    out_d       = out_q;
    tmo_d       = tmo_q;
    cmd_valid_d = cmd_valid_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_d       = err_q;
    ferr_d      = ferr_q;

    hs     = cmd_valid_q & cmd_ready;
    active = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    rdv    = rd_valid & ((state_q == S_READ) || (state_q == S_DRAIN));

    // Read-back checking runs alongside issue in READ and after it in DRAIN.
    if (rdv) begin
      if (rd_data != pat(base_q + chk_q, seed_q)) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (err_q == 16'd0)    ferr_d = base_q + chk_q;
      end
      chk_d = chk_q + ONE_A;
      if (out_q != 4'd0) out_d = out_q - 4'd1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          base_d    = base_addr;
          len_d     = len;
          seed_d    = seed;
          err_d     = 16'd0;
          ferr_d    = '0;
          timeout_d = 1'b0;
          wr_d      = '0;
          rd_d      = '0;
          chk_d     = '0;
          out_d     = 4'd0;
          tmo_d     = '0;
          if (len == '0) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            pass_d      = 1'b1;
            cmd_valid_d = 1'b0;
          end else begin
            state_d     = S_WRITE;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            cmd_valid_d = 1'b1;
            cmd_write_d = 1'b1;
            cmd_addr_d  = base_addr;
            cmd_wdata_d = pat(base_addr, seed);
          end
        end
      end
      S_WRITE: begin
        if (hs) begin
          wr_d = wr_q + ONE_A;
          if (wr_q == len_q - ONE_A) begin
            // First read goes out right behind the last write.
            state_d     = S_READ;
            cmd_write_d = 1'b0;
            cmd_addr_d  = base_q;
            cmd_valid_d = 1'b1;
          end else begin
            cmd_addr_d  = base_q + wr_q + ONE_A;
            cmd_wdata_d = pat(base_q + wr_q + ONE_A, seed_q);
          end
        end
      end
      S_READ: begin
        if (hs) begin
          rd_d  = rd_q + ONE_A;
          out_d = out_d + 4'd1;
        end
        if (rd_d == len_q) begin
          state_d     = S_DRAIN;
          cmd_valid_d = 1'b0;
        end else if (!cmd_valid_q || hs) begin
          cmd_valid_d = (out_d < MAX_OUT_C);
          cmd_addr_d  = base_q + rd_d;
        end
      end
      S_DRAIN: begin
        if (chk_q == len_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == 16'd0);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Progress watchdog: abort when neither a command nor read data moves.
    if (active) begin
      if (hs || rdv) begin
        tmo_d = '0;
      end else if (tmo_q + ONE_T == TMO_C) begin
        tmo_d       = '0;
        timeout_d   = 1'b1;
        cmd_valid_d = 1'b0;
        state_d     = S_DONE;
        done_d      = 1'b1;
        pass_d      = 1'b0;
      end else begin
        tmo_d = tmo_q + ONE_T;
      end
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      seed_q      <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      chk_q       <= '0;
      out_q       <= 4'd0;
      tmo_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= 16'd0;
      ferr_q      <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      seed_q      <= seed_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      chk_q       <= chk_d;
      out_q       <= out_d;
      tmo_q       <= tmo_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      ferr_q      <= ferr_d;
    end
  end

  assign cmd_valid      = cmd_valid_q;
  assign cmd_write      = cmd_write_q;
  assign cmd_addr       = cmd_addr_q;
  assign cmd_wdata      = cmd_wdata_q;
  assign busy           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: a controller/memory model with a command scoreboard, driven by
// a linear sequence of directed tests.
module tb_sdram_pattern_tester;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int MO = 4;

  logic          m_clock = 1'b0;
  logic          p_reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] len = '0;
  logic [DW-1:0] seed = '0;
  logic          cmd_valid, cmd_write;
  logic          cmd_ready = 1'b0;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rd_valid = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;

  sdram_pattern_tester #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO), .TIMEOUT(1023)) dut (
    .m_clock(m_clock), .p_reset(p_reset), .start(start), .base_addr(base_addr), .len(len),
    .seed(seed), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_addr(first_err_addr)
  );

  always #5 m_clock = ~m_clock;

  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  typedef struct {logic [AW-1:0] a; int due;} pend_t;

  wr_t           exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  pend_t         pend[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  int  n_pass = 0, n_fail = 0, n_total = 0;
  int  mode = 0;       // 0 ideal, 1 random stalls/latency, 2 stall forever after first write
  bit  inj = 1'b0;
  int  wr_base = 0;
  int  cyc = 0, wr_hs = 0, tb_out = 0, last_due = 0, stall_rem = 0;
  bit  prev_stall = 1'b0;
  logic [AW+DW:0] prev_cmd = '0;
  logic [DW-1:0]  first_wd = '0, last_wd = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = mem.exists(a) ? mem[a] : '0;
    if (inj && (a == 24'h000103 || a == 24'h000106)) v[0] = ~v[0];
    return v;
  endfunction

  // Controller/memory model: drives ready and read data at the falling edge, then records the
  // handshake that the next rising edge will complete.
  always @(negedge m_clock) begin
    cyc = cyc + 1;
    if (!p_reset) begin
      pend.delete();
      tb_out = 0;
      cmd_ready = 1'b0;
      rd_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      case (mode)
        1: begin
          if (stall_rem > 0) begin
            cmd_ready = 1'b0;
            stall_rem = stall_rem - 1;
          end else begin
            cmd_ready = 1'b1;
            stall_rem = $urandom_range(5, 0);
          end
        end
        2: cmd_ready = (wr_hs == wr_base);
        default: cmd_ready = 1'b1;
      endcase
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        rd_valid = 1'b1;
        rd_data = model_rd(pend[0].a);
        void'(pend.pop_front());
        tb_out = tb_out - 1;
      end else begin
        rd_valid = 1'b0;
        rd_data = DW'($urandom());
      end
      #1;
      if (prev_stall && cmd_valid)
        chk("stall_hold", {cmd_write, cmd_addr, cmd_wdata}, prev_cmd);
      prev_stall = cmd_valid && !cmd_ready;
      prev_cmd = {cmd_write, cmd_addr, cmd_wdata};
      if (cmd_valid && cmd_ready) begin
        if (cmd_write) begin
          if (wr_hs == wr_base) first_wd = cmd_wdata;
          last_wd = cmd_wdata;
          wr_hs = wr_hs + 1;
          mem[cmd_addr] = cmd_wdata;
          if (exp_wr.size() == 0) chk("wr_extra", 1, 0);
          else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("wr_addr", cmd_addr, e.a);
            chk("wr_data", cmd_wdata, e.d);
          end
        end else begin
          pend_t p;
          int lat;
          lat = (mode == 1) ? $urandom_range(8, 3) : 3;
          p.a = cmd_addr;
          p.due = cyc + lat;
          if (p.due <= last_due) p.due = last_due + 1;
          last_due = p.due;
          pend.push_back(p);
          tb_out = tb_out + 1;
          chk("max_out", tb_out <= MO, 1);
          if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
          else chk("rd_addr", cmd_addr, exp_rd.pop_front());
        end
      end
    end
  end

  task automatic start_test(input logic [AW-1:0] b, input logic [AW-1:0] l,
                            input logic [DW-1:0] s, input int m, input bit i);
    exp_wr.delete();
    exp_rd.delete();
    for (int k = 0; k < int'(l); k++) begin
      logic [AW-1:0] a;
      a = b + AW'(k);
      exp_wr.push_back({a, a[DW-1:0] ^ s});
      exp_rd.push_back(a);
    end
    @(negedge m_clock);
    mode = m;
    inj = i;
    wr_base = wr_hs;
    base_addr = b;
    len = l;
    seed = s;
    start = 1'b1;
    @(negedge m_clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < lim) begin
      @(negedge m_clock);
      n = n + 1;
    end
    chk(tag, done, 1);
  endtask

  task automatic end_checks(input string t, input logic [15:0] e_err,
                            input logic [AW-1:0] e_ferr, input logic e_pass);
    chk({t, "_err"}, err_count, e_err);
    chk({t, "_ferr"}, first_err_addr, e_ferr);
    chk({t, "_pass"}, pass, e_pass);
    chk({t, "_busy_valid"}, {busy, cmd_valid}, 0);
    chk({t, "_wr_left"}, exp_wr.size(), 0);
    chk({t, "_rd_left"}, exp_rd.size(), 0);
  endtask

  initial begin
    bit sawv;
    int n;
    #3;
    chk("rst_ctrl", {cmd_valid, cmd_write, busy, done, pass, timeout}, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_wdata", cmd_wdata, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ferr", first_err_addr, 0);
    @(negedge m_clock);
    #2 p_reset = 1'b1;

    // Clean run with an ideal controller.
    start_test(24'h000100, 24'd8, 16'hA5A5, 0, 1'b0);
    wait_done(200, "clean_done");
    end_checks("clean", 16'd0, 24'd0, 1'b1);
    chk("clean_first_wd", first_wd, 16'hA4A5);
    chk("clean_last_wd", last_wd, 16'hA4A2);
    chk("clean_tmo", timeout, 0);

    // Backpressure and variable read latency.
    start_test(24'h000100, 24'd8, 16'hA5A5, 1, 1'b0);
    wait_done(600, "bp_done");
    end_checks("bp", 16'd0, 24'd0, 1'b1);

    // Error injection at 0x103 and 0x106.
    start_test(24'h000100, 24'd8, 16'hA5A5, 0, 1'b1);
    wait_done(200, "inj_done");
    end_checks("inj", 16'd2, 24'h000103, 1'b0);

    // A fresh start after DONE clears the error state.
    start_test(24'h000100, 24'd8, 16'hA5A5, 0, 1'b0);
    chk("restart_clr", {err_count, first_err_addr, done}, 0);
    wait_done(200, "restart_done");
    end_checks("restart", 16'd0, 24'd0, 1'b1);

    // Address wrap.
    start_test(24'hFFFFFE, 24'd4, 16'h1234, 0, 1'b0);
    wait_done(200, "wrap_done");
    end_checks("wrap", 16'd0, 24'd0, 1'b1);

    // Zero-length request.
    start_test(24'h000040, 24'd0, 16'h5555, 0, 1'b0);
    sawv = cmd_valid;
    @(negedge m_clock);
    sawv = sawv | cmd_valid;
    chk("len0_novalid", sawv, 0);
    chk("len0_done_pass", {done, pass, busy}, 3'b110);

    // Start while busy must be ignored.
    start_test(24'h000200, 24'd8, 16'h0F0F, 1, 1'b0);
    repeat (3) @(negedge m_clock);
    base_addr = 24'h000500;
    len = 24'd2;
    seed = 16'h0000;
    start = 1'b1;
    @(negedge m_clock);
    start = 1'b0;
    chk("busy_ign_busy", busy, 1);
    wait_done(600, "busy_ign_done");
    end_checks("busy_ign", 16'd0, 24'd0, 1'b1);

    // Controller stops accepting after the first write.
    start_test(24'h000300, 24'd8, 16'h1111, 2, 1'b0);
    n = 0;
    while (wr_hs == wr_base && n < 20) begin
      @(negedge m_clock);
      n = n + 1;
    end
    chk("tmo_first_wr", wr_hs - wr_base, 1);
    repeat (1000) @(negedge m_clock);
    chk("tmo_early", {done, timeout}, 0);
    wait_done(60, "tmo_done");
    chk("tmo_flags", {timeout, cmd_valid, pass, busy}, 4'b1000);

    // Asynchronous reset in the middle of READ.
    start_test(24'h000100, 24'd8, 16'hA5A5, 0, 1'b0);
    n = 0;
    while (!(cmd_valid && !cmd_write) && n < 100) begin
      @(negedge m_clock);
      n = n + 1;
    end
    chk("rst_mid_reached_read", {cmd_valid, cmd_write, busy}, 3'b101);
    #2 p_reset = 1'b0;
    #1;
    chk("rst_mid_ctrl", {cmd_valid, cmd_write, busy, done, pass, timeout}, 0);
    chk("rst_mid_addr", cmd_addr, 0);
    chk("rst_mid_wdata", cmd_wdata, 0);
    chk("rst_mid_err", {err_count, first_err_addr}, 0);
    @(negedge m_clock);
    @(negedge m_clock);
    #2 p_reset = 1'b1;
    sawv = 1'b0;
    repeat (6) begin
      @(negedge m_clock);
      sawv = sawv | cmd_valid;
    end
    chk("rst_mid_quiet", {sawv, busy}, 0);

    // Recovery after reset.
    start_test(24'h000010, 24'd5, 16'hFFFF, 1, 1'b0);
    wait_done(400, "recover_done");
    end_checks("recover", 16'd0, 24'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
